// File: rtl/asgn_op_arbiter_if.sv
// Request/response bundle for the two-requester assignment-operator arbiter.
// Requester payloads are packed per requester: element i belongs to requester i.
interface asgn_op_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREG  = 4
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  logic [1:0]                 req_valid;
  logic [1:0]                 req_ready;
  logic [1:0][2:0]            req_op;
  logic [1:0]                 req_post;
  logic [1:0][IW-1:0]         req_idx;
  logic [1:0][WIDTH-1:0]      req_data;
  logic                       rsp_valid;
  logic                       rsp_id;
  logic [WIDTH-1:0]           rsp_data;

  modport master (
    output req_valid, req_op, req_post, req_idx, req_data,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_post, req_idx, req_data,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/asgn_op_arbiter.sv
// Round-robin arbiter in front of a small shared register file that executes
// C-style compound assignments (=, +=, -=, *=, >>=, ++, --) one at a time.
module asgn_op_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREG  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  asgn_op_arbiter_if.slave  bus
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [2:0] OP_SET  = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_SRA  = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_READ = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, MUL2 = 2'd2} state_t;

  state_t                   r_state, w_next;
  logic [1:0]               w_grant;
  logic                     w_gid;
  logic [2:0]               r_op;
  logic                     r_post;
  logic [IW-1:0]            r_idx;
  logic signed [WIDTH-1:0]  r_data;
  logic signed [WIDTH-1:0]  r_mul;
  logic                     r_last;
  logic                     r_id;
  logic signed [WIDTH-1:0]  r_regs [NREG];
  logic                     r_rsp_valid;
  logic                     r_rsp_id;
  logic signed [WIDTH-1:0]  r_rsp_data;
  logic signed [WIDTH-1:0]  w_old, w_new, w_rsp;

  // Wrapping result of one compound assignment; no saturation anywhere.
  function automatic logic signed [WIDTH-1:0] f_calc(
    input logic [2:0]              op,
    input logic signed [WIDTH-1:0] old,
    input logic signed [WIDTH-1:0] d
  );
    logic signed [WIDTH-1:0] res;
    case (op)
      OP_SET:  res = d;
      OP_ADD:  res = old + d;
      OP_SUB:  res = old - d;
      OP_MUL:  res = old * d;
      OP_SRA:  res = old >>> d[4:0];
      OP_INC:  res = old + WIDTH'(1);
      OP_DEC:  res = old - WIDTH'(1);
      default: res = old;
    endcase
    return res;
  endfunction

  assign w_old = r_regs[r_idx];
  assign w_new = (r_state == MUL2) ? r_mul : f_calc(r_op, w_old, r_data);
  // Post-increment/decrement and READ hand back the value before the update.
  assign w_rsp = ((r_op == OP_READ) || (r_post && ((r_op == OP_INC) || (r_op == OP_DEC))))
                 ? w_old : w_new;

  always_comb begin
    w_next  = r_state;
    w_grant = 2'b00;
    case (r_state)
      IDLE: begin
        if (rst_n) begin
          case (bus.req_valid)
            2'b01:   w_grant = 2'b01;
            2'b10:   w_grant = 2'b10;
            2'b11:   w_grant = r_last ? 2'b01 : 2'b10;
            default: w_grant = 2'b00;
          endcase
        end
        if (w_grant != 2'b00) w_next = EXEC;
      end
      EXEC:    w_next = (r_op == OP_MUL) ? MUL2 : IDLE;
      MUL2:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_gid         = w_grant[1];
  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
      r_op        <= OP_SET;
      r_post      <= 1'b0;
      r_idx       <= '0;
      r_data      <= '0;
      r_mul       <= '0;
      r_id        <= 1'b0;
      r_last      <= 1'b1;   // "last granted = 1" gives requester 0 first pick
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant != 2'b00) begin
            r_op   <= bus.req_op[w_gid];
            r_post <= bus.req_post[w_gid];
            r_idx  <= bus.req_idx[w_gid];
            r_data <= bus.req_data[w_gid];
            r_id   <= w_gid;
            r_last <= w_gid;
          end
        end
        EXEC: begin
          if (r_op == OP_MUL) begin
            r_mul <= w_new;
          end else begin
            if (r_op != OP_READ) r_regs[r_idx] <= w_new;
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_id;
            r_rsp_data  <= w_rsp;
          end
        end
        MUL2: begin
          r_regs[r_idx] <= r_mul;
          r_rsp_valid   <= 1'b1;
          r_rsp_id      <= r_id;
          r_rsp_data    <= r_mul;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_asgn_op_arbiter.sv
// Scoreboard bench for asgn_op_arbiter: a queue-based reference model predicts
// grants and responses; a separate monitor pops and checks each response.
module tb_asgn_op_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  asgn_op_arbiter_if #(.WIDTH(32), .NREG(4)) bus ();
  asgn_op_arbiter #(.WIDTH(32), .NREG(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [31:0] d;
    int          due;
  } exp_t;
  exp_t q[$];

  logic [31:0] mreg [4];
  logic        mlast;
  int          wait_cnt;
  logic        pend [2];
  logic [2:0]  p_op [2];
  logic        p_post [2];
  logic [1:0]  p_idx [2];
  logic [31:0] p_data [2];
  logic [31:0] last_rsp;

  // Reference semantics of each compound assignment.
  function automatic void ref_op(input logic [2:0] op, input logic post,
                                 input logic [31:0] o, input logic [31:0] d,
                                 output logic [31:0] nv, output logic [31:0] rv);
    case (op)
      3'd0: nv = d;
      3'd1: nv = o + d;
      3'd2: nv = o - d;
      3'd3: nv = o * d;
      3'd4: nv = $signed(o) >>> d[4:0];
      3'd5: nv = o + 32'd1;
      3'd6: nv = o - 32'd1;
      default: nv = o;
    endcase
    rv = ((op == 3'd7) || (post && (op == 3'd5 || op == 3'd6))) ? o : nv;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rsp_valid) begin
        total++;
        last_rsp = bus.rsp_data;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: got id=%0d data=%h at cyc %0d, required none", bus.rsp_id, bus.rsp_data, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (bus.rsp_id !== e.id || bus.rsp_data !== e.d || cyc != e.due) begin
            bad++;
            $display("FAIL rsp: got id=%0d data=%h cyc=%0d, required id=%0d data=%h cyc=%0d",
                     bus.rsp_id, bus.rsp_data, cyc, e.id, e.d, e.due);
          end
        end
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        exp_t e;
        e = q.pop_front();
        total++;
        bad++;
        $display("FAIL rsp_missing: got no rsp_valid at cyc %0d, required id=%0d data=%h", cyc, e.id, e.d);
      end
    end
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic post,
                         input logic [1:0] idx, input logic [31:0] d);
    pend[i]   = 1'b1;
    p_op[i]   = op;
    p_post[i] = post;
    p_idx[i]  = idx;
    p_data[i] = d;
    bus.req_op[i]    = op;
    bus.req_post[i]  = post;
    bus.req_idx[i]   = idx;
    bus.req_data[i]  = d;
    bus.req_valid[i] = 1'b1;
  endtask

  // Called at a falling edge: checks req_ready, models an accept, advances one cycle.
  task automatic step();
    logic [1:0]  v, exp_r;
    logic [31:0] o, nv, rv;
    int          g;
    exp_t        e;
    #1;
    v = {pend[1], pend[0]};
    exp_r = 2'b00;
    if (!rst_n) exp_r = 2'b00;
    else if (wait_cnt > 0) wait_cnt--;
    else if (v == 2'b11) exp_r = mlast ? 2'b01 : 2'b10;
    else exp_r = v;
    total++;
    if (bus.req_ready !== exp_r) begin
      bad++;
      $display("FAIL req_ready: got %b, required %b at cyc %0d", bus.req_ready, exp_r, cyc);
    end
    if (exp_r != 2'b00) begin
      g = exp_r[1] ? 1 : 0;
      o = mreg[p_idx[g]];
      ref_op(p_op[g], p_post[g], o, p_data[g], nv, rv);
      if (p_op[g] != 3'd7) mreg[p_idx[g]] = nv;
      e.id  = exp_r[1];
      e.d   = rv;
      e.due = cyc + 1 + ((p_op[g] == 3'd3) ? 2 : 1);
      q.push_back(e);
      mlast    = exp_r[1];
      wait_cnt = (p_op[g] == 3'd3) ? 2 : 1;
      pend[g]  = 1'b0;
    end
    @(negedge clk);
    bus.req_valid = {pend[1], pend[0]};
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || wait_cnt != 0) && n < 50) begin
      step();
      n++;
    end
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d responses outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic run_one(input int i, input logic [2:0] op, input logic post,
                         input logic [1:0] idx, input logic [31:0] d);
    int n = 0;
    set_req(i, op, post, idx, d);
    while (pend[i] && n < 20) begin
      step();
      n++;
    end
    if (pend[i]) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no grant for requester %0d, required a grant", i);
      pend[i] = 1'b0;
      bus.req_valid[i] = 1'b0;
    end
  endtask

  task automatic expect_last(input string name, input logic [31:0] val);
    drain();
    total++;
    if (last_rsp !== val) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, last_rsp, val);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mreg[k] = 32'd0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    bus.req_valid = 2'b00;
    q.delete();
    mlast    = 1'b1;
    wait_cnt = 0;
  endtask

  task automatic do_reset(input int ncyc);
    #1;
    rst_n = 1'b0;
    model_reset();
    repeat (ncyc) begin
      @(negedge clk);
      #1;
      total++;
      if (bus.req_ready !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.rsp_data !== 32'd0 || bus.rsp_id !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: got ready=%b vld=%b id=%b data=%h, required all zero",
                 bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_data);
      end
    end
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_op    = '0;
    bus.req_post  = 2'b00;
    bus.req_idx   = '0;
    bus.req_data  = '0;
    last_rsp      = 32'd0;
    model_reset();
    do_reset(3);

    // SET then ADD on the same register, back to back
    run_one(0, 3'd0, 1'b0, 2'd0, 32'd99);
    expect_last("set99", 32'd99);
    run_one(0, 3'd1, 1'b0, 2'd0, 32'd1);
    expect_last("add1", 32'd100);

    run_one(1, 3'd0, 1'b0, 2'd1, 32'd100);
    run_one(1, 3'd3, 1'b0, 2'd1, 32'd2);
    expect_last("mul2", 32'd200);
    run_one(1, 3'd4, 1'b0, 2'd1, 32'hFFFF_FFE1);
    expect_last("sra1", 32'd100);

    run_one(0, 3'd5, 1'b0, 2'd2, 32'd0);
    expect_last("inc_pre", 32'd1);
    run_one(0, 3'd5, 1'b1, 2'd2, 32'd0);
    expect_last("inc_post", 32'd1);
    run_one(0, 3'd6, 1'b1, 2'd2, 32'd0);
    expect_last("dec_post", 32'd2);
    run_one(0, 3'd6, 1'b0, 2'd2, 32'd0);
    run_one(0, 3'd6, 1'b0, 2'd2, 32'd0);
    run_one(0, 3'd4, 1'b0, 2'd2, 32'd2);
    expect_last("sra_neg", 32'hFFFF_FFFF);

    run_one(1, 3'd0, 1'b0, 2'd3, 32'h7FFF_FFFF);
    run_one(1, 3'd1, 1'b0, 2'd3, 32'd1);
    expect_last("add_wrap", 32'h8000_0000);
    run_one(0, 3'd7, 1'b0, 2'd3, 32'd5);
    run_one(1, 3'd7, 1'b0, 2'd3, 32'd6);
    expect_last("read", 32'h8000_0000);

    // Both requesters saturating the arbiter right after reset
    do_reset(2);
    set_req(0, 3'd5, 1'b0, 2'd0, 32'd0);
    set_req(1, 3'd5, 1'b0, 2'd1, 32'd0);
    for (int n = 0; n < 16; n++) begin
      step();
      if (!pend[0]) set_req(0, 3'd5, 1'b0, 2'd0, 32'd0);
      if (!pend[1]) set_req(1, 3'd5, 1'b0, 2'd1, 32'd0);
    end
    while (pend[0] || pend[1]) step();
    expect_last("rr_inc", 32'd0 + mreg[1]);

    // Reset in MUL2 must abort the write and the response
    run_one(0, 3'd0, 1'b0, 2'd2, 32'd7);
    drain();
    set_req(0, 3'd3, 1'b0, 2'd2, 32'd3);
    step();
    step();
    do_reset(3);
    run_one(1, 3'd7, 1'b0, 2'd2, 32'd0);
    expect_last("abort_reg", 32'd0);
    run_one(0, 3'd1, 1'b0, 2'd2, 32'd4);
    expect_last("after_abort", 32'd4);

    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0)
          set_req(i, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  ($urandom_range(0, 1) != 0) ? 32'($urandom) : 32'($urandom_range(0, 9)));
      end
      step();
    end
    while (pend[0] || pend[1]) step();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1);
  end
endmodule

// File: doc/asgn_op_arbiter.md
ASGN_OP_ARBITER -- requirements
Module: asgn_op_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, register and operand width in bits, two's-complement signed.
REQ-002 Parameter: NREG, 4, number of shared registers; index width is clog2(NREG).
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  in  2  per-requester request valid; bit i = requester i.
REQ-006 Port: req_ready  out  2  per-requester accept; at most one bit high in any cycle.
REQ-007 Port: req_op  in  2x3  per-requester opcode: 0 SET(=), 1 ADD(+=), 2 SUB(-=), 3 MUL(*=), 4 SRA(>>=), 5 INC, 6 DEC, 7 READ.
REQ-008 Port: req_post  in  2  per-requester post-form flag; honoured for INC/DEC only.
REQ-009 Port: req_idx  in  2xclog2(NREG)  per-requester target register index.
REQ-010 Port: req_data  in  2xWIDTH  per-requester operand.
REQ-011 Port: rsp_valid  out  1  one-cycle pulse marking a completed operation.
REQ-012 Port: rsp_id  out  1  requester that issued the completed operation.
REQ-013 Port: rsp_data  out  WIDTH  value of the assignment expression.

Function
REQ-014 FSM states SHALL be IDLE, EXEC and MUL2; req_ready is nonzero only in IDLE.
REQ-015 In IDLE, req_ready SHALL be combinational: grant to the single valid requester; if both are valid, grant to the requester not granted last (round-robin).
REQ-016 A request is accepted on an edge where req_valid[i] and req_ready[i] are both high; op, post, idx and data are captured and the FSM moves to EXEC.
REQ-017 req_valid/payload SHALL be held by the requester until accepted; a non-granted request is not dropped.
REQ-018 Results: SET new=data; ADD old+data; SUB old-data; MUL low WIDTH bits of old*data; SRA old>>>data[4:0] (arithmetic, shift amount unsigned); INC old+1; DEC old-1; READ no write.
REQ-019 All arithmetic SHALL wrap modulo 2^WIDTH; no saturation or overflow flag.
REQ-020 rsp_data SHALL be the new value, except INC/DEC with post=1 return the old value and READ returns the current value.
REQ-021 Non-MUL: at the EXEC-exit edge the register is written, rsp_valid/rsp_id/rsp_data are registered, FSM returns to IDLE.
REQ-022 MUL: EXEC moves to MUL2; the write and response occur at the MUL2-exit edge, then IDLE.
REQ-023 Latency: accept at edge N; rsp_valid high during cycle N+2 (non-MUL) or N+3 (MUL), for exactly one cycle.
REQ-024 Throughput: next accept possible at edge N+2 (non-MUL) or N+3 (MUL); rsp_valid and the next req_ready may be high in the same cycle.
REQ-025 No response backpressure; rsp_valid is a pulse the consumer must capture.
REQ-026 Register reads in EXEC/MUL2 SHALL see all previously completed writes (no stale data between back-to-back ops on the same index).

Reset
REQ-027 On rst_n low, asynchronously: all registers 0, FSM IDLE, round-robin priority to requester 0, rsp_valid 0, rsp_id 0, rsp_data 0.
REQ-028 req_ready SHALL be 0 while rst_n is low.
REQ-029 Reset asserted mid-operation (EXEC or MUL2) SHALL abort it: no register write, no response.

Verification
REQ-030 Reset, req0 SET idx0 data 99, then req0 ADD idx0 data 1 -> rsp_data 99 then 100, each rsp_valid at accept+2.
REQ-031 Reg1=100; MUL idx1 data 2 -> rsp_data 200 at accept+3; follow with SRA idx1 data 1 (low bits, unsigned shift) -> 100.
REQ-032 Reg2=0; INC post=0 -> 1; INC post=1 -> 1 (reg 2); DEC post=1 -> 2 (reg 1); DEC post=0 -> 0; reg2=-1 via DEC then SRA data 2 -> -1.
REQ-033 Both requesters valid continuously from reset -> grants 0,1,0,1; rsp_id alternates; req_ready never 2'b11.
REQ-034 Reg3=0x7FFFFFFF; ADD data 1 -> 0x80000000 (wrap); READ idx3 -> 0x80000000, no write.
REQ-035 Assert rst_n low during MUL2 -> no rsp_valid, target register 0, FSM IDLE after release.
